// File: rtl/polar_pkg.sv
// Shared types and defaults for the polar_arbiter slice: data width, core latency
// and the tag carried alongside each sample through the topolar core.
package polar_pkg;

    localparam int POLAR_DW      = 32;
    localparam int POLAR_LATENCY = 18;

    // Sized for the largest supported requester count (8); narrower configs zero-extend.
    localparam int MAX_IDW = 3;

    typedef struct packed {
        logic               valid;
        logic [MAX_IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/polar_arbiter_rr.sv
// Round-robin grant generator: searches upward with wrap from the last granted index,
// and moves the pointer to the granted index on each accepted handshake.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);

    logic [IDW-1:0] ptr;
    logic           found;

    // NOTE: every variable assigned here gets a default first, so no latch is inferred.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (int'(ptr) + k) % NREQ;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IDW'(c);
            end
        end
    end

    // Reset to the top index so the first search starts at requester 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= IDW'(NREQ - 1);
        end else if (advance) begin
            ptr <= idx;
        end
    end

endmodule

// File: rtl/polar_arbiter.sv
// Shares one pipelined topolar core between NREQ requesters, returning each result to its issuer.
// Optional grant/in-flight statistics are built when POLAR_ARB_STATS_EN is defined.
module polar_arbiter
    import polar_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = POLAR_DW,
    parameter int LATENCY = POLAR_LATENCY,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NREQ-1:0]   req_vld,
    output logic [NREQ-1:0]   req_rdy,
    input  logic [NREQ*DW-1:0] req_x,
    input  logic [NREQ*DW-1:0] req_y,
    output logic              core_vld,
    output logic [DW-1:0]     core_x,
    output logic [DW-1:0]     core_y,
    input  logic              core_vld_i,
    input  logic [DW-1:0]     core_mag,
    input  logic [DW-1:0]     core_phase,
    output logic [NREQ-1:0]   rsp_vld,
    output logic [DW-1:0]     rsp_mag,
    output logic [DW-1:0]     rsp_phase,
    output logic [IDW-1:0]    rsp_id,
    output logic              err
`ifdef POLAR_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]             stat_cnt,
    output logic [IDW+$clog2(LATENCY):0]   stat_inflight
`endif
);

    logic [NREQ-1:0] req_masked;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            hs;
    logic [IDW-1:0]  issue_id;
    tag_t            tag_line [LATENCY];
    tag_t            tag_in;
    tag_t            tag_out;

    assign req_masked = req_vld & {NREQ{enable & ~rst}};
    assign req_rdy    = gnt;
    assign hs         = |gnt;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req_masked),
        .advance (hs),
        .gnt     (gnt),
        .idx     (gnt_idx)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_vld <= 1'b0;
            core_x   <= '0;
            core_y   <= '0;
            issue_id <= '0;
        end else begin
            core_vld <= hs;
            if (hs) begin
                core_x   <= req_x[gnt_idx*DW +: DW];
                core_y   <= req_y[gnt_idx*DW +: DW];
                issue_id <= gnt_idx;
            end
        end
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = core_vld;
        tag_in.id    = MAX_IDW'(issue_id);
    end

    // NOTE: the tag line is reset (unlike a data RAM) because a mid-stream reset must flush in-flight tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) tag_line[i] <= '0;
        end else begin
            tag_line[0] <= tag_in;
            for (int i = 1; i < LATENCY; i++) tag_line[i] <= tag_line[i-1];
        end
    end

    assign tag_out = tag_line[LATENCY-1];

    // A core valid without a matching tag (or vice versa) is flagged and never forwarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld   <= '0;
            rsp_mag   <= '0;
            rsp_phase <= '0;
            rsp_id    <= '0;
            err       <= 1'b0;
        end else begin
            rsp_vld <= '0;
            if (core_vld_i != tag_out.valid) begin
                err <= 1'b1;
            end else if (core_vld_i) begin
                rsp_vld   <= NREQ'(1) << tag_out.id;
                rsp_mag   <= core_mag;
                rsp_phase <= core_phase;
                rsp_id    <= IDW'(tag_out.id);
            end
        end
    end

`ifdef POLAR_ARB_STATS_EN
    localparam int IFW = IDW + $clog2(LATENCY) + 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i] && stat_cnt[i*16 +: 16] != 16'hFFFF)
                    stat_cnt[i*16 +: 16] <= stat_cnt[i*16 +: 16] + 16'd1;
            end
        end
    end

    always_comb begin
        stat_inflight = '0;
        for (int i = 0; i < LATENCY; i++) stat_inflight = stat_inflight + IFW'(tag_line[i].valid);
    end
`endif

endmodule

// File: tb/tb_polar_arbiter.sv
// Randomized self-checking bench for polar_arbiter with a behavioural topolar stub
// and a queue-based reference model of grants and returned results.
module tb_polar_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int LAT  = 18;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst, enable, inject;
    logic [NREQ-1:0]      req_vld, req_rdy, rsp_vld;
    logic [NREQ*DW-1:0]   req_x, req_y;
    logic                 core_vld, core_vld_i, err;
    logic [DW-1:0]        core_x, core_y, core_mag, core_phase, rsp_mag, rsp_phase;
    logic [IDW-1:0]       rsp_id;

    always #5 clk = ~clk;

    polar_arbiter #(.NREQ(NREQ), .DW(DW), .LATENCY(LAT), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .req_vld    (req_vld),
        .req_rdy    (req_rdy),
        .req_x      (req_x),
        .req_y      (req_y),
        .core_vld   (core_vld),
        .core_x     (core_x),
        .core_y     (core_y),
        .core_vld_i (core_vld_i),
        .core_mag   (core_mag),
        .core_phase (core_phase),
        .rsp_vld    (rsp_vld),
        .rsp_mag    (rsp_mag),
        .rsp_phase  (rsp_phase),
        .rsp_id     (rsp_id),
        .err        (err)
    );

    // Stand-in for the topolar core: fixed latency, mag = x+y, phase = x-y.
    logic          pv [LAT];
    logic [DW-1:0] px [LAT];
    logic [DW-1:0] py [LAT];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= core_vld;
            px[0] <= core_x;
            py[0] <= core_y;
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                px[i] <= px[i-1];
                py[i] <= py[i-1];
            end
        end
    end

    assign core_vld_i = pv[LAT-1] | inject;
    assign core_mag   = px[LAT-1] + py[LAT-1];
    assign core_phase = px[LAT-1] - py[LAT-1];

    typedef struct {
        int            id;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        int            due;
    } exp_t;

    exp_t            q[$];
    int              m_ptr;
    logic            m_err;
    logic            exp_core_vld;
    logic [DW-1:0]   iss_x, iss_y;
    int              cyc;
    int              pulse_cnt;
    logic [NREQ-1:0] obs_rdy;
    int              errors = 0;
    int              checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int exp_grant(input logic [NREQ-1:0] v, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // One clock cycle: check outputs at the falling edge, then advance the model past the rising edge.
    task automatic step();
        int              g;
        logic [NREQ-1:0] exp_rsp;
        logic [DW-1:0]   em, ep;
        @(negedge clk);
        check("core_vld", core_vld, exp_core_vld);
        if (exp_core_vld) begin
            check("core_x", core_x, iss_x);
            check("core_y", core_y, iss_y);
        end
        exp_rsp = '0;
        if (q.size() > 0 && q[0].due == cyc) exp_rsp = NREQ'(1) << q[0].id;
        check("rsp_vld", rsp_vld, exp_rsp);
        if (exp_rsp != '0) begin
            em = q[0].x + q[0].y;
            ep = q[0].x - q[0].y;
            check("rsp_mag", rsp_mag, em);
            check("rsp_phase", rsp_phase, ep);
            check("rsp_id", rsp_id, q[0].id);
            void'(q.pop_front());
        end
        if (rsp_vld != '0) pulse_cnt++;
        check("err", err, m_err);

        g = (rst || !enable) ? -1 : exp_grant(req_vld, m_ptr);
        obs_rdy = req_rdy;
        check("req_rdy", req_rdy, (g < 0) ? '0 : (NREQ'(1) << g));

        if (rst) begin
            q.delete();
            m_ptr        = NREQ - 1;
            m_err        = 1'b0;
            exp_core_vld = 1'b0;
        end else begin
            if (inject) m_err = 1'b1;
            exp_core_vld = (g >= 0);
            if (g >= 0) begin
                m_ptr = g;
                iss_x = req_x[g*DW +: DW];
                iss_y = req_y[g*DW +: DW];
                q.push_back('{id: g, x: iss_x, y: iss_y, due: cyc + LAT + 2});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic randomize_data();
        for (int i = 0; i < NREQ; i++) begin
            req_x[i*DW +: DW] = $urandom();
            req_y[i*DW +: DW] = $urandom();
        end
    endtask

    initial begin
        int c0;
        rst = 1'b1; enable = 1'b1; inject = 1'b0;
        req_vld = '0; req_x = '0; req_y = '0;
        m_ptr = NREQ - 1; m_err = 1'b0; exp_core_vld = 1'b0;
        cyc = 0; pulse_cnt = 0;
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;
        check("rst_core_x", core_x, 0);
        check("rst_core_y", core_y, 0);
        check("rst_rsp_mag", rsp_mag, 0);
        check("rst_rsp_phase", rsp_phase, 0);
        check("rst_rsp_id", rsp_id, 0);

        // Single request from requester 0.
        req_vld = 4'b0001;
        req_x[0 +: DW] = 1572864;
        req_y[0 +: DW] = 1638400;
        step();
        check("single_gnt", obs_rdy, 4'b0001);
        req_vld = '0;
        c0 = pulse_cnt;
        drain(LAT + 4);
        check("single_pulses", pulse_cnt - c0, 1);

        // All requesters valid from a fresh reset: strict rotation.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_vld = 4'b1111;
        c0 = pulse_cnt;
        for (int k = 0; k < 8; k++) begin
            randomize_data();
            step();
            check("rr_all", obs_rdy, NREQ'(1) << (k % NREQ));
        end

        // Requesters 1 and 3 after last grant went to 3.
        req_vld = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            randomize_data();
            step();
            check("rr_13", obs_rdy, (k % 2 == 1) ? 4'b1000 : 4'b0010);
        end
        req_vld = '0;
        drain(LAT + 4);
        check("rr_pulses", pulse_cnt - c0, 11);

        // enable dropped after two grants.
        c0 = pulse_cnt;
        req_vld = 4'b1111;
        randomize_data();
        step();
        step();
        enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("en_off_rdy", obs_rdy, 0);
        end
        req_vld = '0;
        enable  = 1'b1;
        drain(LAT + 4);
        check("en_pulses", pulse_cnt - c0, 2);

        // Reset mid-flight: three issues, five idle cycles, then reset.
        req_vld = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            randomize_data();
            step();
        end
        req_vld = '0;
        drain(5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_core_vld", core_vld, 0);
        check("mid_rst_core_x", core_x, 0);
        check("mid_rst_rsp_vld", rsp_vld, 0);
        check("mid_rst_rsp_mag", rsp_mag, 0);
        check("mid_rst_err", err, 0);
        c0 = pulse_cnt;
        drain(LAT + 4);
        check("flush_pulses", pulse_cnt - c0, 0);
        req_vld = 4'b1111;
        step();
        check("post_rst_gnt", obs_rdy, 4'b0001);
        req_vld = '0;
        drain(LAT + 4);

        // Spurious core valid with an empty tag line.
        c0 = pulse_cnt;
        inject = 1'b1;
        step();
        inject = 1'b0;
        drain(5);
        check("err_sticky", err, 1);
        check("spurious_pulses", pulse_cnt - c0, 0);

        // Randomized traffic.
        for (int k = 0; k < 300; k++) begin
            req_vld = NREQ'($urandom());
            enable  = ($urandom_range(0, 9) != 0);
            randomize_data();
            step();
        end
        req_vld = '0;
        enable  = 1'b1;
        drain(LAT + 4);
        check("queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
